// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
//   tx_state_t : transmitter FSM states
//   OVERSAMPLE : s_tick pulses per serial bit (16x oversampling)
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per tx_start into
// start bit, DBIT data bits (LSB first), optional parity bit, stop period.
// Bit timing comes from the shared 16x oversampling enable s_tick.
//
// Configuration macro: UART_TX_PARITY_EN
//   defined   -> one parity bit (even, or odd when PARITY_ODD=1) after the data
//   undefined -> no parity state, no parity register; PARITY_ODD is ignored
//
// Parameters:
//   DBIT       data bits per frame (5..8)
//   SB_TICK    stop period in s_ticks (16/24/32 = 1/1.5/2 stop bits)
//   PARITY_ODD parity sense, 0 = even, 1 = odd
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   s_tick       16x oversampling enable, one clk wide
//   tx_start     request to send din (ignored unless idle)
//   din          byte to send, bits [DBIT-1:0] are used
//   tx           registered serial line, idle high
//   tx_done_tick one-clk pulse in the last cycle of the stop period
//   tx_busy      high whenever the transmitter is not idle
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_done_tick,
  output logic       tx_busy
);

  // The tick counter must also reach SB_TICK-1 in the stop period.
  localparam int unsigned S_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;

  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [2:0]     N_LAST      = 3'(DBIT - 1);

  if (DBIT < 5 || DBIT > 8 || SB_TICK < 1 || PARITY_ODD > 1) begin : g_cfg_check
    $error("uart_tx: illegal parameter combination");
  end

  tx_state_t      state, state_next;
  logic [S_W-1:0] s, s_next;
  logic [2:0]     n, n_next;
  logic [7:0]     b, b_next;
  logic           tx_next;

`ifdef UART_TX_PARITY_EN
  logic p, p_next;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
      tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      p     <= 1'(PARITY_ODD);
`endif
    end else begin
      state <= state_next;
      s     <= s_next;
      n     <= n_next;
      b     <= b_next;
      tx    <= tx_next;
`ifdef UART_TX_PARITY_EN
      p     <= p_next;
`endif
    end
  end

  always_comb begin
    state_next   = state;
    s_next       = s;
    n_next       = n;
    b_next       = b;
    tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
    p_next       = p;
`endif

    case (state)
      IDLE: begin
        if (tx_start) begin
          state_next = START;
          s_next     = '0;
          b_next     = din;
`ifdef UART_TX_PARITY_EN
          p_next     = 1'(PARITY_ODD);
`endif
        end
      end

      START: begin
        if (s_tick) begin
          if (s == S_BIT_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s == S_BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            p_next = p ^ b[0];
`endif
            b_next = {1'b0, b[7:1]};
            s_next = '0;
            if (n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n + 1'b1;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s == S_BIT_LAST) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
`endif

      STOP: begin
        if (s_tick) begin
          if (s == S_STOP_LAST) begin
            tx_done_tick = 1'b1;
            state_next   = IDLE;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Line level is decoded from the next state so that tx is a flop output
  // and changes on the same edge as the state it belongs to.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = p_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  assign tx_busy = (state != IDLE);

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter serialising one byte per request into an asynchronous frame: start bit, DBIT data bits LSB first, optional parity bit, stop period. It runs from the same 16x oversampling tick as the receiver, driven by `baud_rate_generator`. In the transmit path it sits between the FIFO read side and the serial line, and it is the loopback partner of `rx`.

## Interface
- `DBIT`, 8: data bits per frame, legal range 5–8.
- `SB_TICK`, 16: stop-period length in s_ticks; 16, 24 and 32 give 1, 1.5 and 2 stop bits.
- `PARITY_ODD`, 0: parity sense, 0 = even, 1 = odd. Used only when parity is compiled in.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `s_tick` in 1: 16x oversampling enable, one clk wide, from `baud_rate_generator`.
- `tx_start` in 1: request to send `din`, sampled on clk.
- `din` in 8: data to transmit. Only bits [DBIT-1:0] are sent.
- `tx` out 1: serial line, registered, idle high.
- `tx_done_tick` out 1: one-clk pulse at the end of the stop period.
- `tx_busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
  - PARITY is reachable only with `UART_TX_PARITY_EN`.
- Internal registers:
  - tick counter `s`, 4 bits; it must also reach `SB_TICK-1`, so widen it to `$clog2(SB_TICK)` bits when SB_TICK > 16.
  - bit counter `n`, 3 bits.
  - shift register `b`, 8 bits.
  - parity accumulator `p`, 1 bit.
- IDLE, `tx`=1: on `tx_start`, load `b`←`din`, `s`←0, `p`←PARITY_ODD, go to START. `din` is not sampled again during the frame.
- START, `tx`=0: on each `s_tick`, if `s`==15 then `s`←0, `n`←0, go to DATA; otherwise `s`++.
- DATA, `tx`=`b[0]`: on `s_tick` with `s`==15:
  - `p`←`p`^`b[0]`, then shift `b` right and set `s`←0;
  - if `n`==DBIT-1, go to PARITY (or STOP); otherwise `n`++.
  - On all other `s_tick`s, `s`++.
- PARITY, `tx`=`p`: 16 ticks, then go to STOP with `s`←0.
- STOP, `tx`=1: on `s_tick` with `s`==SB_TICK-1, assert `tx_done_tick` for that clk and go to IDLE.
- `tx_start` outside IDLE is ignored. No queuing, no error flag.
- `s_tick` low: every state holds and every counter freezes.

## Timing
- Reset values:
  - state IDLE; `tx`=1, `tx_done_tick`=0, `tx_busy`=0;
  - `s`, `n`, `b` = 0; `p` = PARITY_ODD.
- `tx` is driven by a flop, so there are no combinational glitches on the line.
- Latency: `tx` falls on the clk edge after `tx_start` is sampled in IDLE. It does not wait for an `s_tick`.
- Frame length is 16·(1+DBIT) + SB_TICK s_ticks, plus 16 with parity. Default: 160 s_ticks.
- End of frame:
  - `tx_done_tick` is high in the same clk as the IDLE transition edge;
  - `tx_busy` falls on that same edge.
- Back-to-back frames: a `tx_start` that is high during the `tx_done_tick` cycle is sampled in IDLE on the next edge. Back-to-back frames therefore need no idle gap beyond the stop period.
- A `tx_start` pulse coinciding with `s_tick` in IDLE is accepted normally.
- Reset mid-frame: `tx` returns high immediately (asynchronous), the frame is abandoned, and no `tx_done_tick` is issued.
- Counter wrap: `s` never exceeds 15 in START, DATA or PARITY, nor SB_TICK-1 in STOP. `n` never exceeds DBIT-1.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - the PARITY state is built;
  - one parity bit follows the data bits, even or odd per PARITY_ODD;
  - the frame grows by 16 s_ticks.
- Not defined:
  - no PARITY state and no `p` register;
  - DATA goes straight to STOP;
  - PARITY_ODD is ignored.

## Structure
- Shared package `uart_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - constant `OVERSAMPLE`=16.
  - `rx` uses the same constant.
- Single flat module. No sub-module is needed. `baud_rate_generator` and `FIFO` are instantiated by the parent, not inside `uart_tx`.

## Test plan
- Reset, then idle: `tx`=1, `tx_busy`=0, `tx_done_tick`=0; `tx` stays 1 for 1000 clks with no `tx_start`.
- `s_tick` every clk, `din`=0xA5, `tx_start` for 1 clk:
  - `tx` low for 16 clks;
  - then bits 1,0,1,0,0,1,0,1 at 16 clks each;
  - then high;
  - `tx_done_tick` exactly 160 clks after the first low.
- Loopback `tx`→`rx`, with `baud_rate_generator` and `dvsr`=0 shared by both: send 0x3C → `rx` `dout`=0x3C and `rx_done_tick` pulses once.
- Start while busy: `tx_start` with `din`=0xFF mid-frame while 0x00 is in flight → the 0x00 frame is unaltered and no second frame follows.
- Back-to-back: `tx_start` held high with `din` 0x55 then 0xAA → two frames with no gap beyond the stop period, and two `tx_done_tick` pulses.
- Reset asserted during DATA → `tx`=1 asynchronously and no `tx_done_tick`. With `UART_TX_PARITY_EN` and PARITY_ODD=0, `din`=0x07 → parity bit 1.
